array_decoder_seq: RTL and testbench
====================================

Name: array_decoder_seq

Overview:
Parametrised, sequenced successor of the left-array row decoder for the Bayesian memristor array.
- Decodes a full row address into an array-select vector and a word-row address.
- Generates a timed CWL (write-line) pulse with programmable width instead of a directly gated CWL input.
- Supports four modes: single-array program, broadcast inference, read-out clear, and a sweep that pulses every array in turn.
- Sits between the top-level control FSM and the array row drivers; exports the same registered {select, CWL, word} bundle downstream.

Parameters:
- NARRAY, 2, number of array-select address bits; there are 2**NARRAY arrays.
- NWORD, 3, word-row address bits.
- N, NWORD+NARRAY, full row address width (derived; do not override).
- PW_BITS, 4, width of the pulse-length field.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  cancel the current operation
- mode  in  2  operation mode: 00 PROGRAM, 01 INFER, 10 READOUT, 11 SWEEP
- adr_full_row  in  N  array bits are [N-1:NWORD]; word bits are [NWORD-1:0]
- pulse_len  in  PW_BITS  CWL high time in cycles; a value of 0 is treated as 1
- busy  out  1  high in SETUP, PULSE and HOLD
- done  out  1  one-cycle completion strobe
- cwl_in  out  2**NARRAY  per-array CWL drive (registered)
- reg_lrs  out  NWORD+2*2**NARRAY  registered bundle {sel_q, cwl_q, word_q}

Behaviour:
- Reset: state=IDLE; all registers 0; busy=0, done=0, cwl_in=0, reg_lrs=0.
- Capture: in IDLE with start=1 and abort=0, latch mode, word address, array index and pulse length (len_q = max(pulse_len,1)), then go to SETUP.
- Select value per mode:
  - PROGRAM: one-hot 1<<array bits.
  - INFER: all ones.
  - READOUT: zero.
  - SWEEP: one-hot 1<<idx, where idx starts at 0 regardless of the address array bits.
- FSM states: IDLE, SETUP, PULSE, HOLD, DONE.
- SETUP (1 cycle): sel_q and word_q loaded; cwl_q=0. For READOUT, sel_q, cwl_q and word_q are cleared and the next state is DONE. Otherwise the next state is PULSE.
- PULSE (len_q cycles): cwl_q=sel_q. The counter loads len_q-1 on entry, decrements each cycle, and exits at 0.
- HOLD (1 cycle): cwl_q=0 and sel_q held.
  - In SWEEP with idx<2**NARRAY-1: idx++ and go to SETUP.
  - Otherwise go to DONE.
- DONE (1 cycle): done=1, busy=0, sel_q held; then IDLE. cwl_q is always 0 outside PULSE.
- Latency (PROGRAM/INFER): start in cycle t gives PULSE in t+2..t+1+L, HOLD in t+2+L, done in t+3+L.
  - SWEEP: done in t+1+2**NARRAY*(L+2).
  - READOUT: done in t+2.
- start outside IDLE is ignored, with no queuing.
- abort in any state other than IDLE: next cycle is IDLE, cwl_q=0, sel_q=0, word_q held, no done. abort and start together in IDLE: abort wins and the block stays IDLE.
- Inputs changing mid-operation have no effect; only the latched values are used.
- Reset asserted mid-pulse: cwl_in drops to 0 asynchronously.
- The counter and idx never wrap. len_q=2**PW_BITS-1 is the maximum pulse length.

Decomposition:
- Package array_dec_pkg holds:
  - the mode enum typedef (MODE_PROGRAM, MODE_INFER, MODE_READOUT, MODE_SWEEP);
  - the FSM state enum;
  - a function sel_decode(mode, idx) returning the select vector, parametrised through NARRAY by the caller.
- One sub-module, cwl_pulse_timer, holds the down-counter:
  - inputs: load, len, clk, rst_n;
  - outputs: active, expire.
- FSM and output registers remain in array_decoder_seq.

Test Plan:
1. PROGRAM, adr_full_row=5'b10_011, pulse_len=3 -> reg_lrs.sel=4'b0100 and word=3'b011 from t+1; cwl_in=4'b0100 for exactly 3 cycles; done at t+6.
2. INFER, pulse_len=0 -> cwl_in=4'b1111 for exactly 1 cycle; done at t+4.
3. SWEEP, pulse_len=2 -> cwl_in pulses 0001, 0010, 0100, 1000 for 2 cycles each, separated by a 0 cycle; done at t+17.
4. READOUT after a program operation -> reg_lrs=0 at t+1; cwl_in never asserted; done at t+2.
5. abort during the 2nd PULSE cycle -> cwl_in=0 and busy=0 the next cycle; done never asserted; a new start is accepted the cycle after.
6. start while busy, plus rst_n low mid-pulse -> the extra start is ignored; reset forces cwl_in=0 and reg_lrs=0 immediately and the FSM returns to IDLE.

Source files
------------

// File: rtl/array_dec_pkg.sv
// Shared types and select decoding for the sequenced array row decoder.
package array_dec_pkg;

  // Widest select vector the decode helper produces; callers cast down to 2**NARRAY bits.
  localparam int SEL_MAX  = 256;
  localparam int IDX_BITS = 8;

  typedef enum logic [1:0] {
    MODE_PROGRAM = 2'b00,
    MODE_INFER   = 2'b01,
    MODE_READOUT = 2'b10,
    MODE_SWEEP   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } state_e;

  // Select vector for a mode: one-hot on idx for PROGRAM/SWEEP, all 2**narray arrays for
  // INFER, nothing for READOUT.
  function automatic logic [SEL_MAX-1:0] sel_decode(input mode_e mode,
                                                    input logic [IDX_BITS-1:0] idx,
                                                    input int unsigned narray);
    logic [SEL_MAX-1:0] s;
    s = '0;
    case (mode)
      MODE_PROGRAM, MODE_SWEEP: s[idx] = 1'b1;
      MODE_INFER: begin
        for (int i = 0; i < SEL_MAX; i++) s[i] = (i < (1 << narray));
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cwl_pulse_timer.sv
// Down-counter timing the CWL high phase; expire marks the last pulse cycle.
module cwl_pulse_timer #(
  parameter int PW_BITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PW_BITS-1:0] len,
  output logic               active,
  output logic               expire
);

  logic [PW_BITS-1:0] cnt_q;
  logic               run_q;

  // Load len-1 on request, count down while running, stop at terminal count (no wrap).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      cnt_q <= len - PW_BITS'(1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - PW_BITS'(1);
    end
  end

  assign active = run_q;
  assign expire = run_q && (cnt_q == '0);

endmodule

// File: rtl/array_decoder_seq.sv
// Sequenced row decoder: array select, word address and a timed CWL pulse per operation.
//
// state | meaning
// IDLE  | waiting for start; select/word hold their last values
// SETUP | select and word driven, CWL low (READOUT clears all and finishes)
// PULSE | CWL follows select for the latched pulse length
// HOLD  | CWL low, select held; SWEEP steps to the next array from here
// DONE  | one-cycle completion strobe
module array_decoder_seq #(
  parameter  int NARRAY  = 2,
  parameter  int NWORD   = 3,
  parameter  int PW_BITS = 4,
  localparam int N       = NWORD + NARRAY,
  localparam int NSEL    = 1 << NARRAY
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [1:0]              mode,
  input  logic [N-1:0]            adr_full_row,
  input  logic [PW_BITS-1:0]      pulse_len,
  output logic                    busy,
  output logic                    done,
  output logic [NSEL-1:0]         cwl_in,
  output logic [NWORD+2*NSEL-1:0] reg_lrs
);

  import array_dec_pkg::*;

  state_e             state;
  mode_e              mode_q;
  mode_e              mode_in;
  logic [NARRAY-1:0]  idx_q;
  logic [NARRAY-1:0]  idx_start;
  logic [NARRAY-1:0]  idx_next;
  logic [PW_BITS-1:0] len_q;
  logic [PW_BITS-1:0] len_start;
  logic [NWORD-1:0]   word_q;
  logic [NSEL-1:0]    sel_q;
  logic [NSEL-1:0]    cwl_q;
  logic               busy_q;
  logic               done_q;
  logic               timer_load;
  logic               timer_active;
  logic               timer_expire;

  assign mode_in   = mode_e'(mode);
  assign idx_start = (mode_in == MODE_SWEEP) ? '0 : adr_full_row[N-1:NWORD];
  assign len_start = (pulse_len == '0) ? PW_BITS'(1) : pulse_len;
  assign idx_next  = idx_q + NARRAY'(1);

  assign timer_load = (state == ST_SETUP) && (mode_q != MODE_READOUT);

  cwl_pulse_timer #(.PW_BITS(PW_BITS)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .len    (len_q),
    .active (timer_active),
    .expire (timer_expire)
  );

  // Operation sequencer with registered select, CWL, word, busy and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_q <= MODE_PROGRAM;
      idx_q  <= '0;
      len_q  <= '0;
      word_q <= '0;
      sel_q  <= '0;
      cwl_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (abort && (state != ST_IDLE)) begin
      state  <= ST_IDLE;
      cwl_q  <= '0;
      sel_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            mode_q <= mode_in;
            idx_q  <= idx_start;
            len_q  <= len_start;
            sel_q  <= NSEL'(sel_decode(mode_in, IDX_BITS'(idx_start), NARRAY));
            word_q <= (mode_in == MODE_READOUT) ? '0 : adr_full_row[NWORD-1:0];
            cwl_q  <= '0;
            busy_q <= 1'b1;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (mode_q == MODE_READOUT) begin
            sel_q  <= '0;
            cwl_q  <= '0;
            word_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            cwl_q <= sel_q;
            state <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          // Leaving on a stopped timer too keeps the FSM from sticking in PULSE.
          if (timer_expire || !timer_active) begin
            cwl_q <= '0;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if ((mode_q == MODE_SWEEP) && (idx_q != {NARRAY{1'b1}})) begin
            idx_q <= idx_next;
            sel_q <= NSEL'(sel_decode(mode_q, IDX_BITS'(idx_next), NARRAY));
            state <= ST_SETUP;
          end else begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          cwl_q  <= '0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign cwl_in  = cwl_q;
  assign reg_lrs = {sel_q, cwl_q, word_q};

endmodule

// File: tb/tb_array_decoder_seq.sv
// Bench for array_decoder_seq: per-cycle comparison against an operation-timeline model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_array_decoder_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  adr = 5'd0;
  logic [3:0]  pulse_len = 4'd0;
  logic        busy;
  logic        done;
  logic [3:0]  cwl_in;
  logic [10:0] reg_lrs;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  array_decoder_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .mode         (mode),
    .adr_full_row (adr),
    .pulse_len    (pulse_len),
    .busy         (busy),
    .done         (done),
    .cwl_in       (cwl_in),
    .reg_lrs      (reg_lrs)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted operation is a timeline indexed by k = cycles since start was taken.
  bit         m_on = 1'b0;
  int         m_k = 0;
  logic [1:0] m_mode = 2'b00;
  logic [3:0] m_s = 4'b0;
  logic [2:0] m_w = 3'b0;
  int         m_l = 1;
  logic [3:0] m_hsel = 4'b0;
  logic [2:0] m_hword = 3'b0;

  function automatic int end_k();
    case (m_mode)
      2'b10:   return 2;
      2'b11:   return 1 + 4 * (m_l + 2);
      default: return 3 + m_l;
    endcase
  endfunction

  function automatic void expect_now(output logic b, output logic d, output logic [3:0] s,
                                     output logic [3:0] c, output logic [2:0] w);
    int e;
    int j;
    int p;
    c = 4'b0;
    if (!m_on) begin
      b = 1'b0; d = 1'b0; s = m_hsel; w = m_hword;
      return;
    end
    e = end_k();
    b = (m_k < e);
    d = (m_k == e);
    case (m_mode)
      2'b10: begin s = 4'b0; w = 3'b0; end
      2'b11: begin
        w = m_w;
        if (m_k < e) begin
          j = (m_k - 1) / (m_l + 2);
          p = (m_k - 1) % (m_l + 2);
          s = 4'b0001 << j;
          if (p >= 1 && p <= m_l) c = s;
        end else begin
          s = 4'b1000;
        end
      end
      default: begin
        s = (m_mode == 2'b01) ? 4'b1111 : m_s;
        w = m_w;
        if (m_k >= 2 && m_k <= 1 + m_l) c = s;
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic       eb, ed;
    logic [3:0] es, ec;
    logic [2:0] ew;
    if (!rst_n) begin
      m_on = 1'b0; m_k = 0; m_hsel = 4'b0; m_hword = 3'b0;
    end else if (m_on) begin
      expect_now(eb, ed, es, ec, ew);
      if (abort) begin
        m_hsel = 4'b0; m_hword = ew; m_on = 1'b0;
      end else if (m_k == end_k()) begin
        m_hsel = es; m_hword = ew; m_on = 1'b0;
      end else begin
        m_k++;
      end
    end else if (start && !abort) begin
      m_on = 1'b1; m_k = 1; m_mode = mode;
      m_s = 4'b0001 << adr[4:3];
      m_w = adr[2:0];
      m_l = (pulse_len == 4'd0) ? 1 : int'(pulse_len);
    end
  end

  always @(negedge clk) begin
    logic       eb, ed;
    logic [3:0] es, ec;
    logic [2:0] ew;
    if (chk_en) begin
      expect_now(eb, ed, es, ec, ew);
      chk("cyc_busy", busy, eb);
      chk("cyc_done", done, ed);
      chk("cyc_cwl", cwl_in, ec);
      chk("cyc_reg_lrs", reg_lrs, {es, ec, ew});
    end
  end

  logic [3:0]  tr_cwl[64];
  logic [10:0] first_lrs;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one start, scramble the inputs, and trace until done or the cycle budget runs out.
  task automatic run_op(input logic [1:0] m, input logic [4:0] a, input logic [3:0] pl,
                        output int done_k, output int cwl_cnt);
    foreach (tr_cwl[i]) tr_cwl[i] = 4'b0;
    mode = m; adr = a; pulse_len = pl; start = 1'b1;
    step();
    start = 1'b0;
    mode = ~m; adr = ~a; pulse_len = pl + 4'd1;
    done_k = -1;
    cwl_cnt = 0;
    for (int k = 1; k < 64 && done_k < 0; k++) begin
      @(negedge clk);
      tr_cwl[k] = cwl_in;
      if (k == 1) first_lrs = reg_lrs;
      if (cwl_in != 4'b0) cwl_cnt++;
      if (done) done_k = k;
      step();
    end
  endtask

  initial begin
    int dk;
    int cc;

    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cwl", cwl_in, 4'b0);
    chk("rst_reg_lrs", reg_lrs, 11'b0);
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();

    run_op(2'b00, 5'b10_011, 4'd3, dk, cc);
    chk("prog_first_lrs", first_lrs, {4'b0100, 4'b0000, 3'b011});
    chk("prog_cwl_cycles", cc, 3);
    chk("prog_cwl_value", tr_cwl[2], 4'b0100);
    chk("prog_done_at", dk, 6);

    run_op(2'b01, 5'b00_101, 4'd0, dk, cc);
    chk("infer_cwl_cycles", cc, 1);
    chk("infer_cwl_value", tr_cwl[2], 4'b1111);
    chk("infer_done_at", dk, 4);

    run_op(2'b11, 5'b10_110, 4'd2, dk, cc);
    chk("sweep_done_at", dk, 17);
    chk("sweep_cwl_cycles", cc, 8);
    chk("sweep_p0", tr_cwl[3], 4'b0001);
    chk("sweep_gap", tr_cwl[4], 4'b0000);
    chk("sweep_p1", tr_cwl[6], 4'b0010);
    chk("sweep_p2", tr_cwl[10], 4'b0100);
    chk("sweep_p3", tr_cwl[15], 4'b1000);

    run_op(2'b00, 5'b01_101, 4'd1, dk, cc);
    chk("prog2_done_at", dk, 4);
    run_op(2'b10, 5'b11_111, 4'd5, dk, cc);
    chk("readout_first_lrs", first_lrs, 11'b0);
    chk("readout_cwl_cycles", cc, 0);
    chk("readout_done_at", dk, 2);

    mode = 2'b00; adr = 5'b01_010; pulse_len = 4'd4; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1;
    @(negedge clk);
    chk("abort_cwl_before", cwl_in, 4'b0010);
    step();
    abort = 1'b0;
    start = 1'b1; mode = 2'b01; pulse_len = 4'd1;
    @(negedge clk);
    chk("abort_cwl_after", cwl_in, 4'b0);
    chk("abort_busy_after", busy, 1'b0);
    chk("abort_done_after", done, 1'b0);
    chk("abort_reg_lrs", reg_lrs, {4'b0000, 4'b0000, 3'b010});
    step();
    start = 1'b0;
    @(negedge clk);
    chk("restart_busy", busy, 1'b1);
    chk("restart_sel", reg_lrs[10:7], 4'b1111);
    repeat (5) step();

    mode = 2'b00; adr = 5'b11_001; pulse_len = 4'd6; start = 1'b1;
    step();
    start = 1'b0;
    step();
    mode = 2'b01; adr = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_ignored", cwl_in, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cwl", cwl_in, 4'b0);
    chk("midrst_reg_lrs", reg_lrs, 11'b0);
    chk("midrst_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    repeat (1500) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 39) == 0);
      mode = 2'($urandom);
      adr = 5'($urandom);
      pulse_len = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (80) step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
